key_debounce_onehot4: RTL and testbench

Four-line key front end that sits directly upstream of the 4-to-2 encoder. It synchronises and debounces four raw key/request lines and qualifies them as a single clean press. Each valid press is presented to the encoder as a held one-hot word on `d0..d3` with a valid/ack handshake. Multi-key presses are rejected with an error pulse, so the encoder only ever sees legal one-hot input or all-zero.

---
 rtl/key_debounce_onehot4_if.sv | 19 +
 rtl/key_debounce_onehot4.sv | 145 ++++++++++++++
 tb/tb_key_debounce_onehot4.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_onehot4_if.sv
// Key/handshake bundle between the raw key lines, the debounce front end and the
// 4-to-2 encoder. The slave side is the front end; the master side drives keys and ack.
interface key_debounce_onehot4_if;
    logic k0, k1, k2, k3;
    logic ack;
    logic d0, d1, d2, d3;
    logic valid;
    logic err;

    modport master (
        output k0, k1, k2, k3, ack,
        input  d0, d1, d2, d3, valid, err
    );

    modport slave (
        input  k0, k1, k2, k3, ack,
        output d0, d1, d2, d3, valid, err
    );
endinterface

// File: rtl/key_debounce_onehot4.sv
// Synchronise, debounce and qualify four key lines into a held one-hot word with valid/ack.
// Optional feature macro: KEY_DEBOUNCE_EN (per-line debounce counters; without it db = synced key).
module key_debounce_onehot4 #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    key_debounce_onehot4_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("key_debounce_onehot4: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [3:0] key_raw;
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [3:0] db;

    assign key_raw = {bus.k3, bus.k2, bus.k1, bus.k0};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= key_raw;
            sync_q <= meta_q;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             db_q, db_d;

        // A mismatch must persist DEBOUNCE_CYCLES edges before the level flips.
        always_comb begin
            cnt_d = '0;
            db_d  = db_q;
            if (sync_q[i] != db_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d = sync_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign db[i] = db_q;
    end
`else
    assign db = sync_q;
`endif

    logic any_key;
    logic one_key;

    assign any_key = |db;
    assign one_key = any_key && ((db & (db - 4'd1)) == 4'd0);

    state_t     state_q, state_d;
    logic [3:0] d_q, d_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (one_key) begin
                    d_d     = db;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (any_key) begin
                    err_d   = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            HOLD: begin
                // Word is frozen here; only the consumer's ack releases it.
                if (valid_q && bus.ack) begin
                    d_d     = '0;
                    valid_d = 1'b0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!any_key) begin
                    state_d = IDLE;
                end
            end
            default: begin
                d_d     = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.d0    = d_q[0];
    assign bus.d1    = d_q[1];
    assign bus.d2    = d_q[2];
    assign bus.d3    = d_q[3];
    assign bus.valid = valid_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_key_debounce_onehot4.sv
// Scoreboard bench for key_debounce_onehot4: stimulus queues timed output events, a
// negedge monitor pops and compares each observed change of {err, valid, d3..d0}.
module tb_key_debounce_onehot4;

    localparam int DC = 4;
`ifdef KEY_DEBOUNCE_EN
    localparam int  LAT           = DC + 2;
    localparam int  REL           = DC + 1;
    localparam bit  GLITCH_PASSES = 1'b0;
`else
    localparam int  LAT           = 2;
    localparam int  REL           = 1;
    localparam bit  GLITCH_PASSES = 1'b1;
`endif

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] keys;
    logic       ack_r;
    int         cyc;
    int         checks;
    int         errors;
    bit         mon_en;
    ev_t        exp_q[$];
    ev_t        ev;
    logic [5:0] cur;
    logic [5:0] prev;

    key_debounce_onehot4_if dut_if ();

    assign dut_if.k0  = keys[0];
    assign dut_if.k1  = keys[1];
    assign dut_if.k2  = keys[2];
    assign dut_if.k3  = keys[3];
    assign dut_if.ack = ack_r;

    key_debounce_onehot4 #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    wire [3:0] d_vec = {dut_if.d3, dut_if.d2, dut_if.d1, dut_if.d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Any change of the outputs must match the next queued event, value and edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {dut_if.err, dut_if.valid, d_vec};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    ev = exp_q.pop_front();
                    check("event_value", 32'(cur), 32'(ev.val));
                    check("event_edge", cyc, ev.cyc);
                end
                prev = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_ev(input int at, input logic e, input logic v, input logic [3:0] d);
        ev_t x;
        x.cyc = at;
        x.val = {e, v, d};
        exp_q.push_back(x);
    endtask

    // Keys driven now are first sampled at edge cyc+1.
    task automatic press_expect(input logic [3:0] on, input logic [3:0] d_exp);
        keys = keys | on;
        expect_ev(cyc + 1 + LAT, 1'b0, 1'b1, d_exp);
    endtask

    task automatic do_ack();
        ack_r = 1'b1;
        expect_ev(cyc + 1, 1'b0, 1'b0, 4'b0000);
        tick(1);
        ack_r = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        prev   = '0;
        keys   = '0;
        ack_r  = 1'b0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("reset_d", 32'(d_vec), 0);
        check("reset_valid", 32'(dut_if.valid), 0);
        check("reset_err", 32'(dut_if.err), 0);
        mon_en = 1'b1;

        // Clean press of k2, held with no ack for 20 cycles.
        tick(1);
        press_expect(4'b0100, 4'b0100);
        tick(LAT + 1 + 20);
        drain("drain_clean", 5);
        check("hold_d", 32'(d_vec), 32'h4);
        check("hold_valid", 32'(dut_if.valid), 1);
        do_ack();
        keys = '0;
        tick(REL + 3);

        // Three-cycle glitch on k1.
        keys[1] = 1'b1;
        if (GLITCH_PASSES) expect_ev(cyc + 1 + LAT, 1'b0, 1'b1, 4'b0010);
        tick(3);
        keys[1] = 1'b0;
        tick(LAT + 4);
        drain("drain_glitch", 5);
        if (GLITCH_PASSES) do_ack();
        tick(REL + 3);

        // Ack while idle must be ignored.
        ack_r = 1'b1;
        tick(1);
        ack_r = 1'b0;
        tick(3);

        // Handshake on k3, held key gives no second press, then k0.
        press_expect(4'b1000, 4'b1000);
        tick(LAT + 2);
        drain("drain_k3", 5);
        do_ack();
        tick(12);
        keys = '0;
        tick(REL + 3);
        press_expect(4'b0001, 4'b0001);
        tick(LAT + 2);
        drain("drain_k0", 5);
        do_ack();
        keys = '0;
        tick(REL + 3);

        // Simultaneous k0+k2: one err pulse, no valid; then k1 is delivered.
        keys = 4'b0101;
        expect_ev(cyc + 1 + LAT, 1'b1, 1'b0, 4'b0000);
        expect_ev(cyc + 2 + LAT, 1'b0, 1'b0, 4'b0000);
        tick(LAT + 6);
        drain("drain_multi", 5);
        keys = '0;
        tick(REL + 3);
        press_expect(4'b0010, 4'b0010);
        tick(LAT + 2);
        drain("drain_k1", 5);
        do_ack();
        keys = '0;
        tick(REL + 3);

        // Staggered k0 then k3: first wins, second ignored until all released.
        press_expect(4'b0001, 4'b0001);
        tick(2);
        keys[3] = 1'b1;
        tick(LAT + 6);
        drain("drain_stagger", 5);
        do_ack();
        tick(4);
        keys = '0;
        tick(REL + 4);

        // Asynchronous reset in HOLD, key held, full re-qualification.
        press_expect(4'b0100, 4'b0100);
        tick(LAT + 2);
        drain("drain_prereset", 5);
        expect_ev(cyc, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #1;
        check("async_rst_d", 32'(d_vec), 0);
        check("async_rst_valid", 32'(dut_if.valid), 0);
        check("async_rst_err", 32'(dut_if.err), 0);
        tick(3);
        rst_n = 1'b1;
        expect_ev(cyc + 1 + LAT, 1'b0, 1'b1, 4'b0100);
        tick(LAT + 3);
        drain("drain_postreset", 5);
        do_ack();
        keys = '0;
        tick(REL + 3);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
